mbus_tx_arbiter: RTL

- Sequencer and 2:1 arbiter in front of the MBus member-layer TX interface (TX_REQ/TX_ACK/TX_PEND/TX_SUCC/TX_FAIL/TX_RESP_ACK).
- Lets two layer-side requesters share one MBus node. Runs the full word-level REQ/ACK handshake and the multi-word PEND chaining, then the SUCC/FAIL response handshake on their behalf.
- Grant is locked from the first word of a message until its response completes. A watchdog flags a stalled bus.

---
 rtl/mbus_tx_arbiter_if.sv | 52 +++++
 rtl/mbus_tx_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mbus_tx_arbiter_if.sv
// Bundle of signals between the TX arbiter, its two layer-side requesters and the MBus node.
// The master modport is the arbiter's view; slave is the requester/node side.
interface mbus_tx_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  REQ0_REQ;
  logic                  REQ1_REQ;
  logic [ADDR_WIDTH-1:0] REQ0_ADDR;
  logic [ADDR_WIDTH-1:0] REQ1_ADDR;
  logic [DATA_WIDTH-1:0] REQ0_DATA;
  logic [DATA_WIDTH-1:0] REQ1_DATA;
  logic                  REQ0_PEND;
  logic                  REQ1_PEND;
  logic                  REQ0_PRIORITY;
  logic                  REQ1_PRIORITY;
  logic                  REQ0_ACK;
  logic                  REQ1_ACK;
  logic                  REQ0_DONE;
  logic                  REQ1_DONE;
  logic                  REQ0_FAIL;
  logic                  REQ1_FAIL;
  logic [ADDR_WIDTH-1:0] TX_ADDR;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_REQ;
  logic                  TX_PEND;
  logic                  TX_PRIORITY;
  logic                  TX_RESP_ACK;
  logic                  TX_ACK;
  logic                  TX_SUCC;
  logic                  TX_FAIL;
  logic                  BUSY;
  logic                  STALL;

  modport master (
    input  REQ0_REQ, REQ1_REQ, REQ0_ADDR, REQ1_ADDR, REQ0_DATA, REQ1_DATA,
    input  REQ0_PEND, REQ1_PEND, REQ0_PRIORITY, REQ1_PRIORITY,
    input  TX_ACK, TX_SUCC, TX_FAIL,
    output REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE, REQ0_FAIL, REQ1_FAIL,
    output TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK,
    output BUSY, STALL
  );

  modport slave (
    output REQ0_REQ, REQ1_REQ, REQ0_ADDR, REQ1_ADDR, REQ0_DATA, REQ1_DATA,
    output REQ0_PEND, REQ1_PEND, REQ0_PRIORITY, REQ1_PRIORITY,
    output TX_ACK, TX_SUCC, TX_FAIL,
    input  REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE, REQ0_FAIL, REQ1_FAIL,
    input  TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK,
    input  BUSY, STALL
  );
endinterface

// File: rtl/mbus_tx_arbiter.sv
// 2:1 arbiter and sequencer for the MBus member-layer TX port: runs the word REQ/ACK handshake,
// PEND chaining and the SUCC/FAIL response handshake on behalf of the granted requester.
module mbus_tx_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [15:0] TIMEOUT    = 16'd1000
) (
  input logic               CLK,
  input logic               RESET,
  mbus_tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSend, StAckLow, StNext, StResp, StRespLow} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  rr_q, rr_d;
  logic [15:0]           wd_q, wd_d;
  logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_req_q, tx_req_d;
  logic                  tx_pend_q, tx_pend_d;
  logic                  tx_prio_q, tx_prio_d;
  logic                  tx_resp_ack_q, tx_resp_ack_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            fail_q, fail_d;
  logic                  busy_q, busy_d;
  logic                  stall_q, stall_d;

  logic [1:0]            req, pend, prio;
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0] data [2];
  logic                  arb_g;
  logic                  resp_in;

  assign req     = {bus.REQ1_REQ, bus.REQ0_REQ};
  assign pend    = {bus.REQ1_PEND, bus.REQ0_PEND};
  assign prio    = {bus.REQ1_PRIORITY, bus.REQ0_PRIORITY};
  assign addr[0] = bus.REQ0_ADDR;
  assign addr[1] = bus.REQ1_ADDR;
  assign data[0] = bus.REQ0_DATA;
  assign data[1] = bus.REQ1_DATA;
  assign resp_in = bus.TX_SUCC | bus.TX_FAIL;

  // Priority beats non-priority; a tie goes to the round-robin favourite.
  always_comb begin
    if (req[0] && req[1]) begin
      arb_g = (prio[0] != prio[1]) ? prio[1] : rr_q;
    end else begin
      arb_g = req[1];
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    tx_addr_d     = tx_addr_q;
    tx_data_d     = tx_data_q;
    tx_req_d      = tx_req_q;
    tx_pend_d     = tx_pend_q;
    tx_prio_d     = tx_prio_q;
    tx_resp_ack_d = tx_resp_ack_q;
    ack_d         = 2'b00;
    done_d        = 2'b00;
    fail_d        = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d   = arb_g;
          tx_addr_d = addr[arb_g];
          tx_data_d = data[arb_g];
          tx_pend_d = pend[arb_g];
          tx_prio_d = prio[arb_g];
          tx_req_d  = 1'b1;
          state_d   = StSend;
        end
      end
      StSend, StAckLow, StNext: begin
        if (bus.TX_FAIL) begin
          // Node aborted mid-message: drop the word unacknowledged and answer the failure now.
          tx_req_d         = 1'b0;
          tx_resp_ack_d    = 1'b1;
          done_d[grant_q]  = 1'b1;
          fail_d[grant_q]  = 1'b1;
          state_d          = StRespLow;
        end else if (state_q == StSend) begin
          if (bus.TX_ACK) begin
            tx_req_d       = 1'b0;
            ack_d[grant_q] = 1'b1;
            state_d        = StAckLow;
          end
        end else if (state_q == StAckLow) begin
          if (!bus.TX_ACK) begin
            state_d = tx_pend_q ? StNext : StResp;
          end
        end else if (req[grant_q]) begin
          tx_addr_d = addr[grant_q];
          tx_data_d = data[grant_q];
          tx_pend_d = pend[grant_q];
          tx_req_d  = 1'b1;
          state_d   = StSend;
        end
      end
      StResp: begin
        if (resp_in) begin
          tx_resp_ack_d   = 1'b1;
          done_d[grant_q] = 1'b1;
          fail_d[grant_q] = bus.TX_FAIL;
          state_d         = StRespLow;
        end
      end
      StRespLow: begin
        if (!resp_in) begin
          tx_resp_ack_d = 1'b0;
          rr_d          = ~grant_q;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wd_d    = wd_q;
    stall_d = stall_q;
    if (state_d != state_q || state_q == StIdle) begin
      wd_d = 16'd0;
    end else if ((state_q inside {StSend, StNext, StResp}) && wd_q != 16'hFFFF) begin
      wd_d = wd_q + 16'd1;
    end
    if (state_d == StIdle) begin
      stall_d = 1'b0;
    end else if (TIMEOUT != 16'd0 && (state_q inside {StSend, StNext, StResp}) &&
                 wd_q == TIMEOUT - 16'd1) begin
      stall_d = 1'b1;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      rr_q          <= 1'b0;
      wd_q          <= 16'd0;
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      tx_req_q      <= 1'b0;
      tx_pend_q     <= 1'b0;
      tx_prio_q     <= 1'b0;
      tx_resp_ack_q <= 1'b0;
      ack_q         <= 2'b00;
      done_q        <= 2'b00;
      fail_q        <= 2'b00;
      busy_q        <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      wd_q          <= wd_d;
      tx_addr_q     <= tx_addr_d;
      tx_data_q     <= tx_data_d;
      tx_req_q      <= tx_req_d;
      tx_pend_q     <= tx_pend_d;
      tx_prio_q     <= tx_prio_d;
      tx_resp_ack_q <= tx_resp_ack_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      busy_q        <= busy_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.TX_ADDR     = tx_addr_q;
  assign bus.TX_DATA     = tx_data_q;
  assign bus.TX_REQ      = tx_req_q;
  assign bus.TX_PEND     = tx_pend_q;
  assign bus.TX_PRIORITY = tx_prio_q;
  assign bus.TX_RESP_ACK = tx_resp_ack_q;
  assign bus.REQ0_ACK    = ack_q[0];
  assign bus.REQ1_ACK    = ack_q[1];
  assign bus.REQ0_DONE   = done_q[0];
  assign bus.REQ1_DONE   = done_q[1];
  assign bus.REQ0_FAIL   = fail_q[0];
  assign bus.REQ1_FAIL   = fail_q[1];
  assign bus.BUSY        = busy_q;
  assign bus.STALL       = stall_q;

endmodule
